// File: rtl/write_data_pkg.sv
// Shared store-type encodings, byte-enable masks and lane helpers for write_data.
package write_data_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned LANE_W    = 8;
  localparam int unsigned NUM_LANES = DATA_W / LANE_W;

  typedef enum logic [1:0] {
    ST_WORD = 2'b00,
    ST_BYTE = 2'b01,
    ST_HALF = 2'b10,
    ST_NONE = 2'b11
  } storeType_e;

  localparam logic [NUM_LANES-1:0] BE_NONE    = 4'b0000;
  localparam logic [NUM_LANES-1:0] BE_ALL     = 4'b1111;
  localparam logic [NUM_LANES-1:0] BE_LO_HALF = 4'b0011;
  localparam logic [NUM_LANES-1:0] BE_HI_HALF = 4'b1100;
  localparam logic [NUM_LANES-1:0] BE_BYTE0   = 4'b0001;

  // Store payload: which lanes are written and the source data replicated onto them.
  typedef struct packed {
    logic [NUM_LANES-1:0] byteEn;
    logic [DATA_W-1:0]    laneData;
  } storeLanes_t;

  function automatic storeLanes_t storeLanes(storeType_e st, logic [1:0] lane,
                                             logic [DATA_W-1:0] src);
    storeLanes_t r;
    r.byteEn   = BE_NONE;
    r.laneData = src;
    case (st)
      ST_WORD: begin
        r.byteEn   = BE_ALL;
        r.laneData = src;
      end
      ST_BYTE: begin
        r.byteEn   = BE_BYTE0 << lane;
        r.laneData = {NUM_LANES{src[LANE_W-1:0]}};
      end
      ST_HALF: begin
        r.byteEn   = lane[1] ? BE_HI_HALF : BE_LO_HALF;
        r.laneData = {2{src[DATA_W/2-1:0]}};
      end
      default: begin
        r.byteEn   = BE_NONE;
        r.laneData = src;
      end
    endcase
    return r;
  endfunction

  function automatic logic isMisaligned(storeType_e st, logic [1:0] lane);
    return ((st == ST_HALF) && lane[0]) || ((st == ST_WORD) && (lane != 2'b00));
  endfunction

endpackage

// File: rtl/write_data_lane_mux.sv
// Per-byte merge: enabled lanes take the store data, the rest keep the memory word.
module write_data_lane_mux
  import write_data_pkg::*;
(
  input  logic [NUM_LANES-1:0] byteEn,
  input  logic [DATA_W-1:0]    laneData,
  input  logic [DATA_W-1:0]    readData,
  output logic [DATA_W-1:0]    mergedData
);

  always_comb begin
    mergedData = readData;
    for (int i = 0; i < int'(NUM_LANES); i++) begin
      if (byteEn[i]) begin
        mergedData[i*LANE_W +: LANE_W] = laneData[i*LANE_W +: LANE_W];
      end
    end
  end

endmodule

// File: rtl/write_data.sv
// Store data merge with byte enables; WRITE_DATA_MISALIGN_CHK_EN enables
// misaligned-store suppression and the sticky MisalignErr flag.
module write_data
  import write_data_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       rd2,
  input  logic [31:0]       ReadData,
  input  logic [1:0]        StoreType,
  input  logic              StoreEn,
  output logic [31:0]       WriteData,
  output logic [3:0]        ByteEn,
  output logic              MisalignErr
);

  storeType_e  storeType;
  storeLanes_t lanes;
  logic        unusedAddr;

  assign storeType  = storeType_e'(StoreType);
  assign lanes      = storeLanes(storeType, Addr[1:0], rd2);
  assign unusedAddr = ^Addr[ADDR_W-1:2];

`ifdef WRITE_DATA_MISALIGN_CHK_EN
  logic misaligned;
  logic misalignErrQ;

  assign misaligned = isMisaligned(storeType, Addr[1:0]);
  // A misaligned store is dropped entirely rather than partially written.
  assign ByteEn     = misaligned ? BE_NONE : lanes.byteEn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalignErrQ <= 1'b0;
    end else if (StoreEn && misaligned) begin
      misalignErrQ <= 1'b1;
    end
  end

  assign MisalignErr = misalignErrQ;
`else
  logic unusedCtl;

  assign ByteEn      = lanes.byteEn;
  assign MisalignErr = 1'b0;
  assign unusedCtl   = ^{clk, rst_n, StoreEn};
`endif

  write_data_lane_mux uLaneMux (
    .byteEn     (ByteEn),
    .laneData   (lanes.laneData),
    .readData   (ReadData),
    .mergedData (WriteData)
  );

endmodule

// File: tb/tb_write_data.sv
// Directed self-checking bench for write_data (both check-feature builds).
module tb_write_data;

  logic        clk;
  logic        rst_n;
  logic [31:0] Addr;
  logic [31:0] rd2;
  logic [31:0] ReadData;
  logic [1:0]  StoreType;
  logic        StoreEn;
  logic [31:0] WriteData;
  logic [3:0]  ByteEn;
  logic        MisalignErr;

  int nCompared   = 0;
  int nMismatched = 0;

`ifdef WRITE_DATA_MISALIGN_CHK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  write_data #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Addr       (Addr),
    .rd2        (rd2),
    .ReadData   (ReadData),
    .StoreType  (StoreType),
    .StoreEn    (StoreEn),
    .WriteData  (WriteData),
    .ByteEn     (ByteEn),
    .MisalignErr(MisalignErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [1:0] st,
                       input logic en);
    Addr      = a;
    rd2       = d;
    StoreType = st;
    StoreEn   = en;
  endtask

  // Apply one combinational vector away from the rising edge and check both outputs.
  task automatic runVec(input string tag, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] st, input logic [31:0] expWd,
                        input logic [3:0] expBe);
    @(negedge clk);
    drive(a, d, st, 1'b0);
    #1;
    checkVal({tag, ".wd"}, WriteData, expWd);
    checkVal({tag, ".be"}, 32'(ByteEn), 32'(expBe));
  endtask

  initial begin
    ReadData = 32'ha5b4c3d2;
    rst_n    = 1'b0;
    drive(32'h0, 32'hffffffff, 2'b01, 1'b1);
    #2;
    checkVal("rst.flag", 32'(MisalignErr), 32'h0);
    checkVal("rst.wd", WriteData, 32'ha5b4c3ff);
    checkVal("rst.be", 32'(ByteEn), 32'h1);
    @(posedge clk);
    #1;
    checkVal("rst.flagEdge", 32'(MisalignErr), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    runVec("sw0",  32'h0, 32'hffffffff, 2'b00, 32'hffffffff, 4'b1111);
    runVec("sb0",  32'h0, 32'hffffffff, 2'b01, 32'ha5b4c3ff, 4'b0001);
    runVec("sb1",  32'h1, 32'hffffffff, 2'b01, 32'ha5b4ffd2, 4'b0010);
    runVec("sb2",  32'h2, 32'hffffffff, 2'b01, 32'ha5ffc3d2, 4'b0100);
    runVec("sb3",  32'h3, 32'hffffffff, 2'b01, 32'hffb4c3d2, 4'b1000);
    runVec("sh0",  32'h0, 32'hffffffff, 2'b10, 32'ha5b4ffff, 4'b0011);
    runVec("sh2",  32'h2, 32'hffffffff, 2'b10, 32'hffffc3d2, 4'b1100);
    runVec("none1", 32'h1, 32'hffffffff, 2'b11, 32'ha5b4c3d2, 4'b0000);
    runVec("none3", 32'h3, 32'hffffffff, 2'b11, 32'ha5b4c3d2, 4'b0000);
    runVec("sbD3", 32'h3, 32'h12345678, 2'b01, 32'h78b4c3d2, 4'b1000);
    runVec("shD2", 32'h2, 32'h12345678, 2'b10, 32'h5678c3d2, 4'b1100);
    runVec("swD0", 32'h0, 32'h12345678, 2'b00, 32'h12345678, 4'b1111);
    runVec("sbHi", 32'hfffffff1, 32'h12345678, 2'b01, 32'ha5b478d2, 4'b0010);
    runVec("shHi", 32'h80000002, 32'h12345678, 2'b10, 32'h5678c3d2, 4'b1100);

    // Misaligned stores: suppressed with the check, lane bits ignored without it.
    runVec("shMis", 32'h1, 32'hffffffff, 2'b10,
           CHK ? 32'ha5b4c3d2 : 32'ha5b4ffff, CHK ? 4'b0000 : 4'b0011);
    runVec("swMis2", 32'h2, 32'h12345678, 2'b00,
           CHK ? 32'ha5b4c3d2 : 32'h12345678, CHK ? 4'b0000 : 4'b1111);
    runVec("swMis7", 32'h7, 32'h12345678, 2'b00,
           CHK ? 32'ha5b4c3d2 : 32'h12345678, CHK ? 4'b0000 : 4'b1111);

    // Misaligned but not committed: flag must stay clear.
    @(posedge clk);
    #1;
    checkVal("flag.noEn", 32'(MisalignErr), 32'h0);

    // Committed misaligned halfword: flag changes only on the edge.
    @(negedge clk);
    drive(32'h1, 32'hffffffff, 2'b10, 1'b1);
    #1;
    checkVal("flag.preEdge", 32'(MisalignErr), 32'h0);
    checkVal("mis.wd", WriteData, CHK ? 32'ha5b4c3d2 : 32'ha5b4ffff);
    @(posedge clk);
    #1;
    checkVal("flag.set", 32'(MisalignErr), 32'(CHK));

    // Sticky through later aligned traffic.
    @(negedge clk);
    drive(32'h0, 32'hffffffff, 2'b00, 1'b1);
    @(posedge clk);
    #1;
    checkVal("flag.hold", 32'(MisalignErr), 32'(CHK));

    // Asynchronous clear mid-cycle.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkVal("flag.asyncClr", 32'(MisalignErr), 32'h0);
    @(negedge clk);
    drive(32'h3, 32'h0, 2'b00, 1'b1);
    rst_n = 1'b1;
    #1;
    checkVal("flag.relNoEdge", 32'(MisalignErr), 32'h0);
    @(posedge clk);
    #1;
    checkVal("flag.relEdge", 32'(MisalignErr), 32'(CHK));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/write_data.md
WRITE_DATA -- requirements
Module: write_data

Interface
REQ-001 Parameter ADDR_W, default 32: width of Addr; only Addr[1:0] affect data merging.
REQ-002 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port Addr  input  ADDR_W  store byte address; Addr[1:0] select the lane.
REQ-005 Port rd2  input  32  store source register value; low bits supply the stored data.
REQ-006 Port ReadData  input  32  current memory word at the aligned address.
REQ-007 Port StoreType  input  2  store size: 00 word (sw), 01 byte (sb), 10 halfword (sh), 11 none.
REQ-008 Port StoreEn  input  1  store is committed this cycle; qualifies error capture only.
REQ-009 Port WriteData  output  32  merged word to write back to memory.
REQ-010 Port ByteEn  output  4  per-byte write enable, bit i covers WriteData[8i+7:8i].
REQ-011 Port MisalignErr  output  1  sticky misaligned-store flag.

Function
REQ-012 WriteData and ByteEn SHALL be purely combinational from Addr, rd2, ReadData and StoreType, with zero-cycle latency and no dependence on clk.
REQ-013 Word (00): WriteData SHALL equal rd2; ByteEn SHALL be 1111.
REQ-014 Byte (01): byte lane Addr[1:0] SHALL be replaced by rd2[7:0]; all other bytes SHALL come from ReadData; ByteEn SHALL be one-hot at bit Addr[1:0].
REQ-015 Halfword (10): half Addr[1] SHALL be replaced by rd2[15:0]; the other half SHALL come from ReadData; ByteEn SHALL be 0011 for Addr[1]=0 and 1100 for Addr[1]=1.
REQ-016 None (11): WriteData SHALL equal ReadData; ByteEn SHALL be 0000.
REQ-017 Without the check feature, Addr[0] SHALL be ignored for halfword stores and Addr[1:0] SHALL be ignored for word stores.
REQ-018 A misaligned store is halfword with Addr[0]=1, or word with Addr[1:0]!=00.
REQ-019 MisalignErr SHALL set on the rising clk edge when StoreEn=1 and the store is misaligned (check feature only), and SHALL hold until reset.
REQ-020 Upper address bits Addr[ADDR_W-1:2] SHALL NOT affect any output.

Reset
REQ-021 rst_n=0 SHALL immediately clear MisalignErr to 0, independent of clk.
REQ-022 WriteData and ByteEn SHALL NOT be affected by reset and SHALL follow their inputs during reset.
REQ-023 After reset release, MisalignErr SHALL first update on the next rising clk edge.

Configuration
REQ-024 Macro WRITE_DATA_MISALIGN_CHK_EN defined: a misaligned store SHALL force WriteData=ReadData and ByteEn=0000, which suppresses the store; MisalignErr SHALL operate per REQ-019.
REQ-025 Macro WRITE_DATA_MISALIGN_CHK_EN undefined: REQ-017 SHALL apply and MisalignErr SHALL be tied to 0.

Structure
REQ-026 Shared package write_data_pkg SHALL hold the StoreType encodings (ST_WORD=00, ST_BYTE=01, ST_HALF=10, ST_NONE=11) and the ByteEn mask constants.
REQ-027 One sub-module, write_data_lane_mux, SHALL implement the per-byte select between rd2 lanes and ReadData from ByteEn. The flag register stays in write_data.

Verification
REQ-028 ReadData=a5b4c3d2, rd2=ffffffff, Addr=0, StoreType=00 -> WriteData=ffffffff, ByteEn=1111.
REQ-029 Same data, StoreType=01, Addr=0/1/2/3 -> WriteData=a5b4c3ff / a5b4ffd2 / a5ffc3d2 / ffb4c3d2, ByteEn=0001/0010/0100/1000.
REQ-030 Same data, StoreType=10, Addr=0 / 2 -> WriteData=a5b4ffff / ffffc3d2.
REQ-031 StoreType=11, any Addr -> WriteData=a5b4c3d2, ByteEn=0000.
REQ-032 Macro defined, StoreType=10, Addr=1, StoreEn=1, one clk edge -> WriteData=a5b4c3d2, ByteEn=0000, MisalignErr=1 and held until rst_n=0, then 0 immediately.
REQ-033 Macro undefined, same stimulus -> WriteData=a5b4ffff, MisalignErr=0.
